// File: rtl/digit_setter_if.sv
// Button/load/number bundle between the push-button front end and the number entry block.
interface digit_setter_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic [DIGITS-1:0] btn;
  logic              dir;
  logic              load;
  logic [W-1:0]      load_val;
  logic [W-1:0]      num;
  logic              changed;

  modport master (output btn, dir, load, load_val, input num, changed);
  modport slave  (input btn, dir, load, load_val, output num, changed);
endinterface

// File: rtl/digit_setter.sv
// DIGITS-digit hex/BCD number stepped per digit by synchronised, edge-detected buttons.
// Define DIGIT_SETTER_CARRY_EN to ripple carry/borrow between digits; otherwise digits wrap independently.
module digit_setter #(
  parameter int unsigned          DIGITS = 4,
  parameter int unsigned          RADIX  = 16,
  parameter logic [4*DIGITS-1:0]  INIT   = (4*DIGITS)'(16'h5360)
) (
  input  logic          clk,
  input  logic          rst,
  digit_setter_if.slave bus
);
  localparam int unsigned W     = 4 * DIGITS;
  localparam logic [3:0]  D_MAX = 4'(RADIX - 1);
  localparam logic [4:0]  R5    = 5'(RADIX);

  logic [DIGITS-1:0] s1, s2, s3;
  logic [DIGITS-1:0] press_c;
  logic [W-1:0]      num_q, num_d, load_c, step_c;
  logic              changed_q, changed_d;

  // Synchroniser, history flop and the registered number
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      num_q     <= INIT;
      changed_q <= 1'b0;
    end else begin
      s1        <= bus.btn;
      s2        <= s1;
      s3        <= s2;
      num_q     <= num_d;
      changed_q <= changed_d;
    end
  end

  assign press_c = s2 & ~s3;

  // BCD loads saturate each out-of-range digit at 9
  always_comb begin
    load_c = bus.load_val;
    if (RADIX == 10) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (load_c[4*i +: 4] > 4'd9) load_c[4*i +: 4] = 4'd9;
      end
    end
  end

`ifdef DIGIT_SETTER_CARRY_EN
  // Ripple add/subtract of RADIX^i per pressed digit; carry out of the top digit is dropped
  always_comb begin
    logic       c;
    logic [4:0] t;
    step_c = num_q;
    c      = 1'b0;
    t      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!bus.dir) begin
        t = {1'b0, num_q[4*i +: 4]} + 5'(press_c[i]) + 5'(c);
        c = (t >= R5);
        if (c) t = t - R5;
      end else begin
        t = {1'b0, num_q[4*i +: 4]} - 5'(press_c[i]) - 5'(c);
        c = t[4];
        if (c) t = t + R5;
      end
      step_c[4*i +: 4] = t[3:0];
    end
  end
`else
  // Each pressed digit wraps on its own
  always_comb begin
    step_c = num_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (press_c[i]) begin
        if (!bus.dir)
          step_c[4*i +: 4] = (num_q[4*i +: 4] == D_MAX) ? 4'd0 : num_q[4*i +: 4] + 4'd1;
        else
          step_c[4*i +: 4] = (num_q[4*i +: 4] == 4'd0) ? D_MAX : num_q[4*i +: 4] - 4'd1;
      end
    end
  end
`endif

  // Load outranks presses; changed flags every write even if the value is unchanged
  always_comb begin
    num_d     = num_q;
    changed_d = 1'b0;
    if (bus.load) begin
      num_d     = load_c;
      changed_d = 1'b1;
    end else if (|press_c) begin
      num_d     = step_c;
      changed_d = 1'b1;
    end
  end

  assign bus.num     = num_q;
  assign bus.changed = changed_q;
endmodule
